// File: rtl/sd_resp_regfile.sv
// sd_resp_regfile
//   Captures one SD card response frame from a serial command line and
//   stores its payload in the CID, CSD, OCR, RCA or status register
//   selected by resp_type. The frame is sampled MSB first and only on
//   cycles where cmd_valid is high. A frame with a bad end bit, or with a
//   bad CRC7 when CRC checking is built, completes with crc_err and leaves
//   every register unchanged.
//
//   Build option: define SD_RESP_CRC_EN to build the CRC7 checker.
//   Without it, only the end bit is checked.
//
//   Ports
//     clk        sole clock, rising edge
//     reset      synchronous, active-high
//     start      arms a capture (honoured only while idle)
//     resp_type  0 none, 1 R1, 2 R2->CID, 3 R2->CSD, 4 R3, 5 R6
//     cmd_in     serial response bit
//     cmd_valid  qualifies cmd_in for one cycle
//     cid_out    CID register
//     csd_out    CSD register
//     ocr_out    OCR register
//     rca_out    RCA register
//     stat_out   [31:0] card status, [37:32] command index, rest 0
//     busy       high whenever not idle
//     done       one-cycle completion pulse
//     crc_err    pulses with done on a frame error
//     timeout    pulses with done when no start bit arrived
//
//   state      | meaning
//   S_IDLE     | waiting for start
//   S_WAIT_ST  | counting 1-strobes until the start bit
//   S_SHIFT    | shifting the rest of the frame in
//   S_CHECK    | one cycle to judge the frame and write the register
//   S_DONE     | one-cycle completion, outputs pulse

module sd_resp_regfile #(
    parameter int           NCR_MAX = 64,
    parameter logic [127:0] CSD_RST = {24'b0, 8'h32, 96'b0},
    parameter logic [31:0]  OCR_RST = 32'h0060_0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   resp_type,
    input  logic         cmd_in,
    input  logic         cmd_valid,
    output logic [127:0] cid_out,
    output logic [127:0] csd_out,
    output logic [31:0]  ocr_out,
    output logic [15:0]  rca_out,
    output logic [63:0]  stat_out,
    output logic         busy,
    output logic         done,
    output logic         crc_err,
    output logic         timeout
);

    localparam int WCW = $clog2(NCR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ST,
        S_SHIFT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [2:0]     rtype;
    logic [WCW-1:0] wait_cnt;
    logic [7:0]     bit_cnt;
    logic [127:0]   shreg;
    logic           err_q, to_q;
    logic [127:0]   cid_q, csd_q;
    logic [31:0]    ocr_q;
    logic [15:0]    rca_q;
    logic [37:0]    stat_q;

    logic           long_frame;
    logic [7:0]     frame_len;
    logic           last_bit;
    logic           wait_expire;
    logic           crc_bad;
    logic           frame_err;

    assign long_frame  = (rtype == 3'd2) || (rtype == 3'd3);
    assign frame_len   = long_frame ? 8'd136 : 8'd48;
    assign last_bit    = (state == S_SHIFT) && cmd_valid && (bit_cnt == frame_len - 8'd1);
    assign wait_expire = (state == S_WAIT_ST) && cmd_valid && cmd_in &&
                         (wait_cnt == WCW'(NCR_MAX - 1));
    assign frame_err   = !shreg[0] || crc_bad;

`ifdef SD_RESP_CRC_EN
    logic [6:0] crc;
    logic [7:0] bit_num;
    logic       crc_cover;
    logic       crc_fb;

    // bit_num is the 1-based position of the bit being received. Short
    // frames cover everything up to the CRC; the start bit is a zero and
    // leaves a cleared CRC untouched. R2 skips its 8-bit header.
    assign bit_num   = bit_cnt + 8'd1;
    assign crc_cover = (bit_num <= frame_len - 8'd8) && (!long_frame || bit_num >= 8'd9);
    assign crc_fb    = crc[6] ^ cmd_in;
    assign crc_bad   = (rtype != 3'd4) && (crc != shreg[7:1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            crc <= '0;
        end else if (state == S_IDLE) begin
            crc <= '0;
        end else if (state == S_SHIFT && cmd_valid && crc_cover) begin
            crc <= {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
        end
    end
`else
    assign crc_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start && resp_type != 3'd0) state_nxt = S_WAIT_ST;
            S_WAIT_ST: if (cmd_valid) begin
                           if (!cmd_in)         state_nxt = S_SHIFT;
                           else if (wait_expire) state_nxt = S_DONE;
                       end
            S_SHIFT:   if (last_bit) state_nxt = S_CHECK;
            S_CHECK:   state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rtype    <= 3'd0;
            wait_cnt <= '0;
            bit_cnt  <= 8'd0;
            shreg    <= '0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            cid_q    <= '0;
            csd_q    <= CSD_RST;
            ocr_q    <= OCR_RST;
            rca_q    <= '0;
            stat_q   <= '0;
        end else begin
            case (state)
                S_IDLE: if (start && resp_type != 3'd0) begin
                    rtype    <= resp_type;
                    wait_cnt <= '0;
                    bit_cnt  <= 8'd0;
                    err_q    <= 1'b0;
                    to_q     <= 1'b0;
                end
                S_WAIT_ST: if (cmd_valid) begin
                    if (!cmd_in) begin
                        // the start bit counts as frame bit 1
                        bit_cnt <= 8'd1;
                        shreg   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                        if (wait_expire) to_q <= 1'b1;
                    end
                end
                S_SHIFT: if (cmd_valid) begin
                    shreg   <= {shreg[126:0], cmd_in};
                    bit_cnt <= bit_cnt + 8'd1;
                end
                S_CHECK: begin
                    err_q <= frame_err;
                    if (!frame_err) begin
                        case (rtype)
                            3'd1: stat_q <= {shreg[45:40], shreg[39:8]};
                            3'd2: cid_q  <= shreg;
                            3'd3: csd_q  <= shreg;
                            3'd4: ocr_q  <= shreg[39:8];
                            3'd5: begin
                                rca_q  <= shreg[39:24];
                                stat_q <= {shreg[45:40], 16'h0, shreg[23:8]};
                            end
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    assign cid_out  = cid_q;
    assign csd_out  = csd_q;
    assign ocr_out  = ocr_q;
    assign rca_out  = rca_q;
    assign stat_out = {26'h0, stat_q};
    assign busy     = (state != S_IDLE);
    assign done     = (state == S_DONE);
    assign crc_err  = done && err_q;
    assign timeout  = done && to_q;

endmodule

// File: tb/tb_sd_resp_regfile.sv
// tb_sd_resp_regfile
//   Randomized bench for sd_resp_regfile. Frames are built from random
//   payloads with a bench-side CRC7, optionally corrupted, and sent with
//   random cmd_valid gaps and stray start pulses. Expected register values
//   and pulse timing are kept as scheduled events and compared every cycle.

module tb_sd_resp_regfile;

    localparam int           NCR     = 64;
    localparam logic [127:0] CSD_RST = {24'b0, 8'h32, 96'b0};
    localparam logic [31:0]  OCR_RST = 32'h0060_0000;
    localparam int           BIG     = 32'h3fff_ffff;
`ifdef SD_RESP_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset, start, cmd_in, cmd_valid;
    logic [2:0]   resp_type;
    logic [127:0] cid_out, csd_out;
    logic [31:0]  ocr_out;
    logic [15:0]  rca_out;
    logic [63:0]  stat_out;
    logic         busy, done, crc_err, timeout;

    sd_resp_regfile dut (
        .clk(clk), .reset(reset), .start(start), .resp_type(resp_type),
        .cmd_in(cmd_in), .cmd_valid(cmd_valid),
        .cid_out(cid_out), .csd_out(csd_out), .ocr_out(ocr_out),
        .rca_out(rca_out), .stat_out(stat_out),
        .busy(busy), .done(done), .crc_err(crc_err), .timeout(timeout)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // schedule written by the driver, read by the compare process
    int           done_edge  = -1;
    int           busy_from  = BIG;
    int           reset_edge = -1;
    int           pend_type  = 0;
    logic [127:0] pend_frame = '0;
    bit           exp_crc = 1'b0, exp_to = 1'b0;
    bit           cmp_en = 1'b0;

    // model state, written only by the compare process
    logic [127:0] exp_cid, exp_csd;
    logic [31:0]  exp_ocr;
    logic [15:0]  exp_rca;
    logic [63:0]  exp_stat;

    int n_checks = 0, n_fail = 0;
    int n_done_seen = 0, n_crc_seen = 0, n_to_seen = 0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [6:0] crc7_of(input logic [135:0] f, input int hi, input int lo);
        logic [6:0] c = 7'h0;
        logic       fb;
        for (int i = hi; i >= lo; i--) begin
            fb = c[6] ^ f[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    // kind: 0 good, 1 CRC bit flipped, 2 end bit cleared
    function automatic logic [135:0] build_frame(input logic [2:0] t, input logic [127:0] rnd, input int kind);
        logic [135:0] f = '0;
        if (t == 3'd2 || t == 3'd3) begin
            f = {2'b00, 6'h3F, rnd[119:0], 8'h01};
            f[7:1] = crc7_of(f, 127, 8);
        end else begin
            f[47:0] = {2'b00, rnd[37:32], rnd[31:0], 8'h01};
            f[7:1] = crc7_of(f, 47, 8);
        end
        if (kind == 1) f[1] = ~f[1];
        if (kind == 2) f[0] = 1'b0;
        return f;
    endfunction

    function automatic bit frame_err(input logic [2:0] t, input int kind);
        return (kind == 2) || (kind == 1 && CRC_EN && t != 3'd4);
    endfunction

    initial begin
        bit ed, eb;
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                if (cyc == reset_edge) begin
                    exp_cid = '0; exp_csd = CSD_RST; exp_ocr = OCR_RST;
                    exp_rca = '0; exp_stat = '0;
                end
                if (cyc == done_edge) begin
                    case (pend_type)
                        1: exp_stat = {26'h0, pend_frame[45:40], pend_frame[39:8]};
                        2: exp_cid  = pend_frame;
                        3: exp_csd  = pend_frame;
                        4: exp_ocr  = pend_frame[39:8];
                        5: begin
                            exp_rca  = pend_frame[39:24];
                            exp_stat = {26'h0, pend_frame[45:40], 16'h0, pend_frame[23:8]};
                        end
                        default: ;
                    endcase
                end
                ed = (cyc == done_edge);
                eb = (cyc >= busy_from) && (cyc <= done_edge);
                check("busy", busy, eb);
                check("done", done, ed);
                check("crc_err", crc_err, ed && exp_crc);
                check("timeout", timeout, ed && exp_to);
                check("cid_out", cid_out, exp_cid);
                check("csd_out", csd_out, exp_csd);
                check("ocr_out", ocr_out, exp_ocr);
                check("rca_out", rca_out, exp_rca);
                check("stat_out", stat_out, exp_stat);
                if (done === 1'b1)    n_done_seen++;
                if (crc_err === 1'b1) n_crc_seen++;
                if (timeout === 1'b1) n_to_seen++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int gap;
        gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
        for (int g = 0; g < gap; g++) begin
            cmd_valid = 1'b0;
            cmd_in    = 1'($urandom_range(0, 1));
            start     = ($urandom_range(0, 3) == 0);
            resp_type = 3'($urandom_range(0, 7));
            tick();
        end
        start = 1'b0; cmd_valid = 1'b1; cmd_in = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    // stray starts while busy must be ignored
    task automatic wait_idle();
        while (cyc <= done_edge) begin
            start     = 1'($urandom_range(0, 1));
            resp_type = 3'($urandom_range(1, 7));
            tick();
        end
        start = 1'b0;
    endtask

    task automatic issue_start(input logic [2:0] t);
        int gap;
        wait_idle();
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        start = 1'b1; resp_type = t;
        tick();
        start = 1'b0; resp_type = 3'($urandom_range(0, 7));
        busy_from = cyc;
        done_edge = BIG;
    endtask

    task automatic run_frame(input logic [2:0] t, input logic [135:0] f, input bit err,
                             input int nones, input int reset_at);
        int len, sent;
        len = (t == 3'd2 || t == 3'd3) ? 136 : 48;
        issue_start(t);
        for (int i = 0; i < nones; i++) begin
            send_bit(1'b1);
            if (i == NCR - 1) begin
                exp_to = 1'b1; exp_crc = 1'b0; pend_type = 0;
                done_edge = cyc;
                return;
            end
        end
        send_bit(1'b0);
        sent = 1;
        for (int i = len - 2; i >= 0; i--) begin
            send_bit(f[i]);
            sent++;
            if (sent == reset_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                pend_type  = 0;
                reset_edge = cyc;
                done_edge  = -1;
                busy_from  = BIG;
                return;
            end
        end
        exp_crc    = err;
        exp_to     = 1'b0;
        pend_type  = err ? 0 : int'(t);
        pend_frame = f[127:0];
        done_edge  = cyc + 1;
    endtask

    initial begin
        logic [135:0] f, f2;
        logic [127:0] rnd;
        logic [2:0]   t;
        int           s_done, s_crc, s_to, kind, nones, r;

        reset = 1'b1; start = 1'b0; resp_type = 3'd0; cmd_in = 1'b1; cmd_valid = 1'b0;
        tick();
        tick();
        reset_edge = cyc;
        cmp_en     = 1'b1;
        reset      = 1'b0;
        tick();
        check("reset_ocr", ocr_out, 32'h0060_0000);
        check("reset_csd", csd_out, {24'b0, 8'h32, 96'b0});

        f = 136'h11_0000_0900_67;
        check("crc7_model", crc7_of(f, 47, 8), 7'h33);

        // 64 strobes of 1 on an R3 capture: timeout, OCR untouched
        s_to = n_to_seen; s_done = n_done_seen;
        run_frame(3'd4, '0, 1'b0, NCR, 0);
        wait_idle();
        check("r3_timeout_pulse", n_to_seen - s_to, 1);
        check("r3_timeout_done", n_done_seen - s_done, 1);
        check("r3_timeout_ocr", ocr_out, 32'h0060_0000);

        s_crc = n_crc_seen;
        f = 136'h11_0000_0900_67;
        run_frame(3'd1, f, 1'b0, 3, 0);
        wait_idle();
        check("r1_stat", stat_out, 64'h0000_0011_0000_0900);
        check("r1_no_crc_err", n_crc_seen - s_crc, 0);

        s_crc = n_crc_seen; s_done = n_done_seen;
        f = 136'h11_0000_0900_65;
        run_frame(3'd1, f, CRC_EN, 0, 0);
        wait_idle();
        check("r1_bad_crc_stat", stat_out, 64'h0000_0011_0000_0900);
        check("r1_bad_crc_err", n_crc_seen - s_crc, int'(CRC_EN));
        check("r1_bad_crc_done", n_done_seen - s_done, 1);

        rnd = {$urandom, $urandom, $urandom, $urandom};
        rnd[31:16] = 16'hB368;
        f = build_frame(3'd5, rnd, 0);
        run_frame(3'd5, f, 1'b0, 5, 0);
        wait_idle();
        check("r6_rca", rca_out, 16'hB368);
        check("r6_cid_hold", cid_out, 128'h0);
        check("r6_csd_hold", csd_out, {24'b0, 8'h32, 96'b0});

        // 63 ones is one short of the timeout
        s_to = n_to_seen;
        rnd = {$urandom, $urandom, $urandom, $urandom};
        f = build_frame(3'd1, rnd, 0);
        run_frame(3'd1, f, 1'b0, NCR - 1, 0);
        wait_idle();
        check("ncr_minus_one_no_timeout", n_to_seen - s_to, 0);

        // reset at bit 70 of an R2 capture
        s_done = n_done_seen;
        rnd = {$urandom, $urandom, $urandom, $urandom};
        f = build_frame(3'd2, rnd, 0);
        run_frame(3'd2, f, 1'b0, 2, 70);
        for (int i = 0; i < 5; i++) tick();
        check("r2_reset_cid", cid_out, 128'h0);
        check("r2_reset_no_done", n_done_seen - s_done, 0);
        rnd = {$urandom, $urandom, $urandom, $urandom};
        f2 = build_frame(3'd2, rnd, 0);
        run_frame(3'd2, f2, 1'b0, 1, 0);
        wait_idle();
        check("r2_after_reset_cid", cid_out, f2[127:0]);

        for (int it = 0; it < 30; it++) begin
            t   = 3'($urandom_range(1, 5));
            rnd = {$urandom, $urandom, $urandom, $urandom};
            r   = $urandom_range(0, 9);
            kind = (r < 6) ? 0 : ((r < 8) ? 1 : 2);
            r   = $urandom_range(0, 9);
            nones = (r == 0) ? NCR : ((r == 1) ? NCR - 1 : $urandom_range(0, 8));
            f = build_frame(t, rnd, kind);
            run_frame(t, f, frame_err(t, kind), nones, 0);
            if ($urandom_range(0, 3) == 0) begin
                wait_idle();
                start = 1'b1; resp_type = 3'd0;
                tick();
                start = 1'b0;
            end
        end
        wait_idle();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "time limit");
    end

endmodule
